edge_detector_nch: RTL and testbench

Parametrised multi-channel edge detector. It is the successor to the single-channel Mealy/Moore edge detector. Each of CHANNELS asynchronous level inputs goes through a synchroniser and a debounce filter. Each channel then produces registered one-cycle rise/fall ticks, a mode-gated edge tick and a sticky event flag. The block sits between external/slow status lines and the control logic that consumes single-cycle event pulses.

---
 rtl/edge_detector_nch.sv | 83 ++++++++
 tb/tb_edge_detector_nch.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detector_nch.sv
// rtl/edge_detector_nch.sv - multi-channel synchronised, debounced edge detector with sticky flags
// Each channel: sync chain -> debounce counter/accepted level -> registered ticks and sticky flag.

module edge_detector_nch #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CHANNELS-1:0]     level,
  input  logic [2*CHANNELS-1:0]   mode,
  input  logic [CHANNELS-1:0]     flag_clr,
  output logic [CHANNELS-1:0]     rise_tick,
  output logic [CHANNELS-1:0]     fall_tick,
  output logic [CHANNELS-1:0]     edge_tick,
  output logic [CHANNELS-1:0]     event_flags
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);

  genvar i;
  for (i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] w_sync_next;
    logic                   r_acc;
    logic [CW-1:0]          r_cnt;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_edge;
    logic                   r_flag;
    logic                   w_s;
    logic                   w_last;
    logic                   w_rise;
    logic                   w_fall;

    if (SYNC_STAGES > 1) begin : g_chain
      assign w_sync_next = {r_sync[SYNC_STAGES-2:0], level[i]};
    end else begin : g_single
      assign w_sync_next = level[i];
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_last = (r_cnt == LAST_CNT);
    // Acceptance happens on the D-th consecutive edge where s differs from the accepted level.
    assign w_rise = w_s & ~r_acc & w_last;
    assign w_fall = ~w_s & r_acc & w_last;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_sync <= '0;
        r_acc  <= 1'b0;
        r_cnt  <= '0;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        r_edge <= 1'b0;
        r_flag <= 1'b0;
      end else begin
        r_sync <= w_sync_next;
        if (w_s == r_acc) begin
          r_cnt <= '0;
        end else if (w_last) begin
          r_acc <= w_s;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
        r_rise <= w_rise;
        r_fall <= w_fall;
        r_edge <= (w_rise & mode[2*i]) | (w_fall & mode[2*i+1]);
        // Set wins over a coincident clear.
        r_flag <= r_edge | (r_flag & ~flag_clr[i]);
      end
    end

    assign rise_tick[i]   = r_rise;
    assign fall_tick[i]   = r_fall;
    assign edge_tick[i]   = r_edge;
    assign event_flags[i] = r_flag;
  end

endmodule

// File: tb/tb_edge_detector_nch.sv
// tb/tb_edge_detector_nch.sv - directed and randomized self-checking bench for edge_detector_nch
// Reference model judges acceptance by a window over the history of synchronised samples.

module tb_edge_detector_nch;

  localparam int CH   = 4;
  localparam int S    = 2;
  localparam int D    = 4;
  localparam int MAXE = 4096;

  logic          clk;
  logic          reset;
  logic [CH-1:0] level;
  logic [2*CH-1:0] mode;
  logic [CH-1:0] flag_clr;
  logic [CH-1:0] rise_tick;
  logic [CH-1:0] fall_tick;
  logic [CH-1:0] edge_tick;
  logic [CH-1:0] event_flags;

  edge_detector_nch #(
    .CHANNELS        (CH),
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .level       (level),
    .mode        (mode),
    .flag_clr    (flag_clr),
    .rise_tick   (rise_tick),
    .fall_tick   (fall_tick),
    .edge_tick   (edge_tick),
    .event_flags (event_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Model state: per-edge history of raw and synchronised samples.
  bit lvl_h [CH][MAXE];
  bit s_h   [CH][MAXE];
  int last_acc [CH];
  bit acc_lvl  [CH];
  int n  = 0;
  int n0 = 1;
  logic [CH-1:0] exp_rise = '0;
  logic [CH-1:0] exp_fall = '0;
  logic [CH-1:0] exp_edge = '0;
  logic [CH-1:0] exp_flag = '0;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("rise_tick", rise_tick, exp_rise);
    check("fall_tick", fall_tick, exp_fall);
    check("edge_tick", edge_tick, exp_edge);
    check("event_flags", event_flags, exp_flag);
  endtask

  task automatic model_reset();
    exp_rise = '0;
    exp_fall = '0;
    exp_edge = '0;
    exp_flag = '0;
    for (int c = 0; c < CH; c++) begin
      acc_lvl[c]  = 1'b0;
      last_acc[c] = n;
    end
    n0 = n + 1;
  endtask

  task automatic model_edge();
    logic [CH-1:0] nr, nf, ne, nfl;
    bit s, acc;
    n++;
    if (n >= MAXE) begin
      $display("FAIL model_history_overflow edges=%0d limit=%0d", n, MAXE);
      $fatal(1);
    end
    if (reset) begin
      model_reset();
      return;
    end
    for (int c = 0; c < CH; c++) begin
      lvl_h[c][n] = level[c];
      s = (n - S >= n0) ? lvl_h[c][n-S] : 1'b0;
      s_h[c][n] = s;
      acc = (n - D + 1 > last_acc[c]);
      if (acc)
        for (int k = 0; k < D; k++)
          if (s_h[c][n-k] == acc_lvl[c]) acc = 1'b0;
      nr[c] = acc & ~acc_lvl[c];
      nf[c] = acc & acc_lvl[c];
      if (acc) begin
        acc_lvl[c]  = ~acc_lvl[c];
        last_acc[c] = n;
      end
      ne[c]  = (nr[c] & mode[2*c]) | (nf[c] & mode[2*c+1]);
      nfl[c] = exp_edge[c] | (exp_flag[c] & ~flag_clr[c]);
    end
    exp_rise = nr;
    exp_fall = nf;
    exp_edge = ne;
    exp_flag = nfl;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time_limit_exceeded");
    $fatal(1);
  end

  int cnt_r, cnt_f, cnt_e;
  logic [1:0] sweep_mode [4];
  int sweep_exp [4];

  initial begin
    // Reset and idle
    reset    = 1'b1;
    level    = '0;
    mode     = '0;
    flag_clr = '0;
    #1;
    check_outputs();
    #2;
    reset = 1'b0;
    for (int k = 0; k < 20; k++) step();

    // Clean rise then fall on ch0, mode 01
    mode[1:0] = 2'b01;
    level[0]  = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check("lat_rise0", rise_tick[0], (k == 6));
      check("lat_edge0", edge_tick[0], (k == 6));
    end
    for (int k = 0; k < 10; k++) step();
    check("flag0_sticky", event_flags[0], 1'b1);
    level[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      check("lat_fall0", fall_tick[0], (k == 6));
      check("fall_edge0_gated", edge_tick[0], 1'b0);
    end
    for (int k = 0; k < 6; k++) step();

    // Glitch rejection on ch1: 3 high cycles rejected, 4 accepted
    cnt_r = 0;
    cnt_f = 0;
    level[1] = 1'b1;
    for (int k = 0; k < 3; k++) step();
    level[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      cnt_r += rise_tick[1];
      cnt_f += fall_tick[1];
    end
    check("glitch3_rise", cnt_r[3:0], 4'd0);
    check("glitch3_fall", cnt_f[3:0], 4'd0);
    level[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      cnt_r += rise_tick[1];
      cnt_f += fall_tick[1];
    end
    level[1] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      cnt_r += rise_tick[1];
      cnt_f += fall_tick[1];
    end
    check("pulse4_rise", cnt_r[3:0], 4'd1);
    check("pulse4_fall", cnt_f[3:0], 4'd1);

    // Mode sweep on ch2
    sweep_mode[0] = 2'b00; sweep_exp[0] = 0;
    sweep_mode[1] = 2'b10; sweep_exp[1] = 1;
    sweep_mode[2] = 2'b11; sweep_exp[2] = 2;
    sweep_mode[3] = 2'b01; sweep_exp[3] = 1;
    for (int m = 0; m < 4; m++) begin
      cnt_r = 0;
      cnt_f = 0;
      cnt_e = 0;
      mode[5:4] = sweep_mode[m];
      for (int t = 0; t < 2; t++) begin
        level[2] = ~level[2];
        for (int k = 0; k < 20; k++) begin
          step();
          cnt_r += rise_tick[2];
          cnt_f += fall_tick[2];
          cnt_e += edge_tick[2];
        end
      end
      check("sweep_edge2", cnt_e[3:0], sweep_exp[m][3:0]);
      check("sweep_rise2", cnt_r[3:0], 4'd1);
      check("sweep_fall2", cnt_f[3:0], 4'd1);
    end

    // Sticky flag on ch3: clear, then clear coinciding with edge_tick
    mode[7:6] = 2'b11;
    level[3]  = 1'b1;
    for (int k = 0; k < 7; k++) step();
    check("flag3_set", event_flags[3], 1'b1);
    flag_clr[3] = 1'b1;
    step();
    flag_clr[3] = 1'b0;
    check("flag3_cleared", event_flags[3], 1'b0);
    level[3] = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check("edge3_high", edge_tick[3], 1'b1);
    flag_clr[3] = 1'b1;
    step();
    flag_clr[3] = 1'b0;
    check("flag3_set_wins", event_flags[3], 1'b1);
    for (int k = 0; k < 4; k++) step();

    // Reset mid-debounce with ch0 held high
    level[0] = 1'b1;
    for (int k = 0; k < 4; k++) step();
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs();
    step();
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      check("rst_lat_rise0", rise_tick[0], (k == 6));
    end

    // All channels rising together
    level = '0;
    for (int k = 0; k < 12; k++) step();
    level = 4'hF;
    for (int k = 1; k <= 6; k++) begin
      step();
      check("all_rise", rise_tick, (k == 6) ? 4'hF : 4'h0);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs();
        step();
        reset = 1'b0;
      end
      for (int ch = 0; ch < CH; ch++)
        if ($urandom_range(0, 5) == 0) level[ch] = ~level[ch];
      if ($urandom_range(0, 49) == 0) mode = 8'($urandom);
      flag_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
